// File: rtl/pwm_multi_channel.sv
// N-channel PWM generator with prescaler, programmable period, edge/center alignment and
// double-buffered registers that move to the active set only at a period boundary.
module pwm_multi_channel #(
    parameter int unsigned NUM_CH  = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned PRESC_W = 4,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);

    localparam logic [ADDR_W-1:0] ADDR_TOP   = ADDR_W'(NUM_CH);
    localparam logic [ADDR_W-1:0] ADDR_PRESC = ADDR_W'(NUM_CH + 1);
    localparam logic [ADDR_W-1:0] ADDR_MODE  = ADDR_W'(NUM_CH + 2);

    logic [CNT_W-1:0]   duty_sh  [NUM_CH];
    logic [CNT_W-1:0]   duty_act [NUM_CH];
    logic [CNT_W-1:0]   top_sh, top_act;
    logic [PRESC_W-1:0] presc_sh, presc_act;
    logic               mode_sh, mode_act;

    logic [PRESC_W-1:0] presc_cnt;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               dir_down, dir_down_next;
    logic               tick, boundary, reload;

    // Shadow registers, written from the register front end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) duty_sh[i] <= '0;
            top_sh   <= '1;
            presc_sh <= '0;
            mode_sh  <= 1'b0;
        end else if (wr_en) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (wr_addr == ADDR_W'(i)) duty_sh[i] <= wr_data;
            end
            if (wr_addr == ADDR_TOP)   top_sh   <= wr_data;
            if (wr_addr == ADDR_PRESC) presc_sh <= wr_data[PRESC_W-1:0];
            if (wr_addr == ADDR_MODE)  mode_sh  <= wr_data[0];
        end
    end

    assign tick = en && (presc_cnt == presc_act);

    always_comb begin
        cnt_next      = cnt;
        dir_down_next = dir_down;
        if (tick) begin
            if (!mode_act) begin
                cnt_next      = (cnt >= top_act) ? '0 : cnt + CNT_W'(1);
                dir_down_next = 1'b0;
            end else if (top_act == '0) begin
                cnt_next      = '0;
                dir_down_next = 1'b0;
            end else if (!dir_down) begin
                if (cnt >= top_act) begin
                    // Turn around at TOP; with TOP = 1 the turn lands directly on 0.
                    cnt_next      = top_act - CNT_W'(1);
                    dir_down_next = (top_act > CNT_W'(1));
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end else begin
                if (cnt <= CNT_W'(1)) begin
                    cnt_next      = '0;
                    dir_down_next = 1'b0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
        end
    end

    assign boundary = tick && (cnt_next == '0);
    assign reload   = !en || boundary;

    // Active copies; nonblocking reads give the pre-write shadow value on a coincident write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) duty_act[i] <= '0;
            top_act   <= '1;
            presc_act <= '0;
            mode_act  <= 1'b0;
        end else if (reload) begin
            for (int i = 0; i < int'(NUM_CH); i++) duty_act[i] <= duty_sh[i];
            top_act   <= top_sh;
            presc_act <= presc_sh;
            mode_act  <= mode_sh;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
            cnt       <= '0;
            dir_down  <= 1'b0;
        end else if (!en) begin
            presc_cnt <= '0;
            cnt       <= '0;
            dir_down  <= 1'b0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
            cnt       <= cnt_next;
            dir_down  <= dir_down_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out     <= '0;
            period_tick <= 1'b0;
        end else begin
            period_tick <= boundary;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                pwm_out[i] <= en & ch_en[i] & (cnt < duty_act[i]);
            end
        end
    end

endmodule
